// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the matrix processor.
// Lines are loaded over DataIn and fetched with a two-edge registered latency.
// Fetch data is captured on the request edge, so a fetch and a write to the same
// line on one edge return the old contents.
module instr_mem_loadable #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned UNIT_ID = 2,
   parameter logic [INSTR_W-1:0] STOP_OP = INSTR_W'(32'hFF00_0000)
) (
   input  logic                            Clk,
   input  logic                            nReset,
   input  logic [15:0]                     address,
   input  logic                            nRead,
   input  logic                            nWrite,
   input  logic [LINE_W-1:0]               DataIn,
   output logic [LINE_W-1:0]               InstructDataOut,
   output logic                            DataValid,
   output logic                            AddrError,
   output logic [$clog2(DEPTH+1)-1:0]      ProgLen
);

   localparam int unsigned SLOTS = LINE_W / INSTR_W;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PL_W  = $clog2(DEPTH + 1);
   localparam logic [LINE_W-1:0] STOP_LINE = {SLOTS{STOP_OP}};
   localparam logic [12:0] DEPTH_L = 13'(DEPTH);

   logic [LINE_W-1:0] r_mem [DEPTH];
   logic              r_nwrite_q;
   logic              r_req_v;
   logic [LINE_W-1:0] r_req_data;
   logic [LINE_W-1:0] r_dout;
   logic              r_dvalid;
   logic              r_addr_err;
   logic [PL_W-1:0]   r_prog_len;

   logic              w_sel;
   logic [11:0]       w_idx;
   logic [AW-1:0]     w_midx;
   logic              w_inrange;
   logic              w_rd;
   logic              w_wr;
   logic [12:0]       w_idx_p1;

   assign w_sel     = (address[15:12] == 4'(UNIT_ID));
   assign w_idx     = address[11:0];
   assign w_midx    = w_idx[AW-1:0];
   assign w_inrange = ({1'b0, w_idx} < DEPTH_L);
   assign w_rd      = w_sel & ~nRead;
   // Write only on the first clock of each nWrite low pulse
   assign w_wr      = w_sel & ~nWrite & r_nwrite_q;
   assign w_idx_p1  = {1'b0, w_idx} + 13'd1;

   // Line storage; every line holds the STOP line out of reset
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= STOP_LINE;
         end
      end else if (w_wr && w_inrange) begin
         r_mem[w_midx] <= DataIn;
      end
   end

   // Fetch pipeline, write-edge detect, error flag and program length
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_nwrite_q <= 1'b1;
         r_req_v    <= 1'b0;
         r_req_data <= '0;
         r_dout     <= '0;
         r_dvalid   <= 1'b0;
         r_addr_err <= 1'b0;
         r_prog_len <= '0;
      end else begin
         r_nwrite_q <= nWrite;
         r_req_v    <= w_rd;
         if (w_rd) begin
            r_req_data <= w_inrange ? r_mem[w_midx] : STOP_LINE;
         end
         r_dvalid <= r_req_v;
         if (r_req_v) begin
            r_dout <= r_req_data;
         end
         if ((w_rd || w_wr) && !w_inrange) begin
            r_addr_err <= 1'b1;
         end
         if (w_wr && w_inrange && (w_idx_p1 > 13'(r_prog_len))) begin
            r_prog_len <= PL_W'(w_idx_p1);
         end
      end
   end

   assign InstructDataOut = r_dout;
   assign DataValid       = r_dvalid;
   assign AddrError       = r_addr_err;
   assign ProgLen         = r_prog_len;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: table-driven load/stream/range vectors
// plus hand sequences for reset, single-write hold, foreign unit and collision.
module tb_instr_mem_loadable;

   localparam logic [255:0] STOP = {8{32'hFF00_0000}};
   localparam logic [255:0] LOAD = {8{32'h0102_0001}};
   localparam logic [255:0] ALT  = {8{32'hDEAD_BEEF}};

   logic         Clk;
   logic         nReset;
   logic [15:0]  address;
   logic         nRead;
   logic         nWrite;
   logic [255:0] DataIn;
   logic [255:0] InstructDataOut;
   logic         DataValid;
   logic         AddrError;
   logic [4:0]   ProgLen;

   int total;
   int bad;

   instr_mem_loadable #(
      .DEPTH(16), .LINE_W(256), .INSTR_W(32), .UNIT_ID(2), .STOP_OP(32'hFF00_0000)
   ) dut (
      .Clk(Clk), .nReset(nReset), .address(address), .nRead(nRead), .nWrite(nWrite),
      .DataIn(DataIn), .InstructDataOut(InstructDataOut), .DataValid(DataValid),
      .AddrError(AddrError), .ProgLen(ProgLen)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic         nr;
      logic         nw;
      logic [15:0]  addr;
      logic [255:0] din;
      logic         e_v;
      logic [255:0] e_dout;
      logic         e_err;
      logic [4:0]   e_pl;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [255:0] line_of(input logic [31:0] k);
      return {8{32'hA000_0000 | k}};
   endfunction

   function automatic vec_t mk(input logic nr, input logic nw, input logic [15:0] a,
                               input logic [255:0] d, input logic ev,
                               input logic [255:0] ed, input logic ee, input logic [4:0] ep);
      vec_t v;
      v.nr = nr; v.nw = nw; v.addr = a; v.din = d;
      v.e_v = ev; v.e_dout = ed; v.e_err = ee; v.e_pl = ep;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, return just after the next rising edge
   task automatic step(input logic nr, input logic nw, input logic [15:0] a,
                       input logic [255:0] d);
      @(negedge Clk);
      nRead = nr; nWrite = nw; address = a; DataIn = d;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 16'h2000, '0);
   endtask

   task automatic reset_pulse();
      nRead = 1'b1; nWrite = 1'b1;
      nReset = 1'b0;
      #2;
      nReset = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      nReset = 1'b0; nRead = 1'b1; nWrite = 1'b1; address = 16'h0000; DataIn = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      nReset = 1'b1;
      idle();
      // junk the outputs are not sensitive to, then a mid-cycle reset pulse
      reset_pulse();
      chk("rst_dout",  InstructDataOut, '0);
      chk("rst_valid", 256'(DataValid), '0);
      chk("rst_err",   256'(AddrError), '0);
      chk("rst_pl",    256'(ProgLen),   '0);

      // first fetch after reset returns the STOP line
      step(1'b0, 1'b1, 16'h2000, '0);
      chk("rst_fetch_lat", 256'(DataValid), 256'(0));
      idle();
      chk("rst_fetch_valid", 256'(DataValid), 256'(1));
      chk("rst_fetch_dout",  InstructDataOut, STOP);
      idle();
      chk("rst_fetch_strobe", 256'(DataValid), 256'(0));

      // held nWrite writes exactly once
      step(1'b1, 1'b0, 16'h2003, LOAD);
      chk("load_pl", 256'(ProgLen), 256'(4));
      step(1'b1, 1'b0, 16'h2003, ALT);
      step(1'b1, 1'b0, 16'h2003, ALT);
      idle();
      step(1'b0, 1'b1, 16'h2003, '0);
      idle();
      chk("load_valid", 256'(DataValid), 256'(1));
      chk("load_dout",  InstructDataOut, LOAD);

      // load lines 0-3, stream them, out-of-range fetch, ProgLen saturation
      tbl.push_back(mk(1,0,16'h2000,line_of(0), 0,LOAD,0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,LOAD,0,4));
      tbl.push_back(mk(1,0,16'h2001,line_of(1), 0,LOAD,0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,LOAD,0,4));
      tbl.push_back(mk(1,0,16'h2002,line_of(2), 0,LOAD,0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,LOAD,0,4));
      tbl.push_back(mk(1,0,16'h2003,line_of(3), 0,LOAD,0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,LOAD,0,4));
      tbl.push_back(mk(0,1,16'h2000,'0,         0,LOAD,0,4));
      tbl.push_back(mk(0,1,16'h2001,'0,         1,line_of(0),0,4));
      tbl.push_back(mk(0,1,16'h2002,'0,         1,line_of(1),0,4));
      tbl.push_back(mk(0,1,16'h2003,'0,         1,line_of(2),0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         1,line_of(3),0,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,line_of(3),0,4));
      tbl.push_back(mk(0,1,16'h2010,'0,         0,line_of(3),1,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         1,STOP,1,4));
      tbl.push_back(mk(0,1,16'h2001,'0,         0,STOP,1,4));
      tbl.push_back(mk(1,1,16'h2000,'0,         1,line_of(1),1,4));
      tbl.push_back(mk(1,0,16'h200F,line_of(15),0,line_of(1),1,16));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,line_of(1),1,16));
      tbl.push_back(mk(1,0,16'h2000,line_of(0), 0,line_of(1),1,16));
      tbl.push_back(mk(1,1,16'h2000,'0,         0,line_of(1),1,16));
      tbl.push_back(mk(0,1,16'h200F,'0,         0,line_of(1),1,16));
      tbl.push_back(mk(1,1,16'h2000,'0,         1,line_of(15),1,16));
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].nr, tbl[i].nw, tbl[i].addr, tbl[i].din);
         chk($sformatf("vec%0d_valid", i), 256'(DataValid), 256'(tbl[i].e_v));
         chk($sformatf("vec%0d_dout", i),  InstructDataOut,   tbl[i].e_dout);
         chk($sformatf("vec%0d_err", i),   256'(AddrError), 256'(tbl[i].e_err));
         chk($sformatf("vec%0d_pl", i),    256'(ProgLen),   256'(tbl[i].e_pl));
      end

      // reset while a fetch is in flight aborts it and restores STOP lines
      step(1'b0, 1'b1, 16'h2001, '0);
      reset_pulse();
      chk("abort_err", 256'(AddrError), '0);
      chk("abort_pl",  256'(ProgLen),   '0);
      idle();
      chk("abort_valid", 256'(DataValid), '0);
      chk("abort_dout",  InstructDataOut, '0);
      step(1'b0, 1'b1, 16'h2001, '0);
      idle();
      chk("abort_mem", InstructDataOut, STOP);

      // foreign unit is ignored
      step(1'b1, 1'b0, 16'h3002, ALT);
      idle();
      step(1'b0, 1'b1, 16'h3002, '0);
      idle();
      chk("foreign_valid", 256'(DataValid), '0);
      chk("foreign_err",   256'(AddrError), '0);
      chk("foreign_pl",    256'(ProgLen),   '0);
      step(1'b0, 1'b1, 16'h2002, '0);
      idle();
      chk("foreign_mem", InstructDataOut, STOP);

      // same-edge fetch and write to one line: old data first, new data next
      step(1'b1, 1'b0, 16'h2005, line_of(5));
      idle();
      step(1'b0, 1'b0, 16'h2005, line_of(6));
      idle();
      chk("coll_valid", 256'(DataValid), 256'(1));
      chk("coll_old",   InstructDataOut, line_of(5));
      step(1'b0, 1'b1, 16'h2005, '0);
      idle();
      chk("coll_new", InstructDataOut, line_of(6));
      chk("coll_pl",  256'(ProgLen), 256'(6));

      // out-of-range write flags error and leaves ProgLen alone
      step(1'b1, 1'b0, 16'h2FFF, ALT);
      chk("oor_wr_err", 256'(AddrError), 256'(1));
      chk("oor_wr_pl",  256'(ProgLen),   256'(6));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
